// File: rtl/dice_pkg.sv
// Shared definitions for the dice referee: FSM state encoding, winner codes and legal die faces.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P1_TURN = 2'd1,
    P2_TURN = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  function automatic logic face_ok(input logic [2:0] face);
    return (face >= FACE_MIN) && (face <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_score_acc.sv
// 8-bit saturating score accumulator; clear wins over add. sum_o is the would-be next score,
// so the referee can judge the win condition in the same cycle as the roll.
module dice_score_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       add_en_i,
  input  logic [2:0] add_val_i,
  output logic [7:0] score_o,
  output logic [7:0] sum_o
);

  logic [7:0] score_q;
  logic [8:0] raw_sum;

  assign raw_sum = {1'b0, score_q} + {6'b0, add_val_i};
  assign sum_o   = raw_sum[8] ? 8'hFF : raw_sum[7:0];
  assign score_o = score_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= 8'd0;
    end else if (clr_i) begin
      score_q <= 8'd0;
    end else if (add_en_i) begin
      score_q <= sum_o;
    end
  end

endmodule

// File: rtl/dice_referee.sv
// Two-player dice game referee: alternating valid/ready roll intake, saturating scores,
// win on target score or on points after the round limit. Reset release is expected synchronous to clk.
module dice_referee
  import dice_pkg::*;
#(
  parameter int TARGET_SCORE = 50,
  parameter int MAX_ROUNDS   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       roll1_valid,
  input  logic [2:0] roll1_value,
  output logic       roll1_ready,
  input  logic       roll2_valid,
  input  logic [2:0] roll2_value,
  output logic       roll2_ready,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic       turn,
  output logic [7:0] round_cnt,
  output logic       end_of_game,
  output logic [1:0] winner,
  output logic       bad_roll
);

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  logic [7:0] round_q, round_d, round_inc;
  logic       bad_q, bad_d;
  logic       clr, add1, add2;
  logic [7:0] sum1, sum2;

  dice_score_acc u_acc1 (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (clr),
    .add_en_i  (add1),
    .add_val_i (roll1_value),
    .score_o   (score1),
    .sum_o     (sum1)
  );

  dice_score_acc u_acc2 (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (clr),
    .add_en_i  (add2),
    .add_val_i (roll2_value),
    .score_o   (score2),
    .sum_o     (sum2)
  );

  assign round_inc = round_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    round_d  = round_q;
    bad_d    = 1'b0;
    clr      = 1'b0;
    add1     = 1'b0;
    add2     = 1'b0;
    // start overrides everything, including a roll handshake in the same cycle
    if (start) begin
      clr      = 1'b1;
      round_d  = 8'd0;
      winner_d = WIN_NONE;
      state_d  = P1_TURN;
    end else begin
      case (state_q)
        P1_TURN: begin
          if (roll1_valid) begin
            if (!face_ok(roll1_value)) begin
              bad_d = 1'b1;
            end else begin
              add1 = 1'b1;
              if (int'(sum1) >= TARGET_SCORE) begin
                state_d  = DONE;
                winner_d = WIN_P1;
              end else begin
                state_d = P2_TURN;
              end
            end
          end
        end
        P2_TURN: begin
          if (roll2_valid) begin
            if (!face_ok(roll2_value)) begin
              bad_d = 1'b1;
            end else begin
              add2 = 1'b1;
              if (int'(sum2) >= TARGET_SCORE) begin
                state_d  = DONE;
                winner_d = WIN_P2;
              end else begin
                round_d = round_inc;
                if (round_inc == 8'(MAX_ROUNDS)) begin
                  state_d  = DONE;
                  winner_d = (score1 > sum2) ? WIN_P1 :
                             (score1 < sum2) ? WIN_P2 : WIN_TIE;
                end else begin
                  state_d = P1_TURN;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      winner_q <= WIN_NONE;
      round_q  <= 8'd0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      round_q  <= round_d;
      bad_q    <= bad_d;
    end
  end

  assign roll1_ready = (state_q == P1_TURN);
  assign roll2_ready = (state_q == P2_TURN);
  assign turn        = (state_q == P2_TURN);
  assign end_of_game = (state_q == DONE);
  assign round_cnt   = round_q;
  assign winner      = winner_q;
  assign bad_roll    = bad_q;

endmodule

// File: tb/tb_dice_referee.sv
// Directed bench for dice_referee: a vector table plus hand-written multi-cycle sequences.
module tb_dice_referee;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [2:0] d1 = 3'd0, d2 = 3'd0;

  logic       a_r1, a_r2, a_trn, a_eog, a_bad;
  logic [7:0] a_s1, a_s2, a_rnd;
  logic [1:0] a_win;
  logic       b_r1, b_r2, b_trn, b_eog, b_bad;
  logic [7:0] b_s1, b_s2, b_rnd;
  logic [1:0] b_win;
  logic       c_r1, c_r2, c_trn, c_eog, c_bad;
  logic [7:0] c_s1, c_s2, c_rnd;
  logic [1:0] c_win;

  integer n_tests = 0;
  integer n_fail  = 0;

  always #5 clk = ~clk;

  // main instance: target 20, 3 rounds
  dice_referee #(.TARGET_SCORE(20), .MAX_ROUNDS(3)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .roll1_valid(v1), .roll1_value(d1), .roll1_ready(a_r1),
    .roll2_valid(v2), .roll2_value(d2), .roll2_ready(a_r2),
    .score1(a_s1), .score2(a_s2), .turn(a_trn), .round_cnt(a_rnd),
    .end_of_game(a_eog), .winner(a_win), .bad_roll(a_bad));

  // a 3-round limit cannot let P1 reach 20, so the target-win case uses 4 rounds
  dice_referee #(.TARGET_SCORE(20), .MAX_ROUNDS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .roll1_valid(v1), .roll1_value(d1), .roll1_ready(b_r1),
    .roll2_valid(v2), .roll2_value(d2), .roll2_ready(b_r2),
    .score1(b_s1), .score2(b_s2), .turn(b_trn), .round_cnt(b_rnd),
    .end_of_game(b_eog), .winner(b_win), .bad_roll(b_bad));

  // unreachable target, long game: exercises saturation at 255
  dice_referee #(.TARGET_SCORE(300), .MAX_ROUNDS(200)) dut_c (
    .clk(clk), .reset(reset), .start(start),
    .roll1_valid(v1), .roll1_value(d1), .roll1_ready(c_r1),
    .roll2_valid(v2), .roll2_value(d2), .roll2_ready(c_r2),
    .score1(c_s1), .score2(c_s2), .turn(c_trn), .round_cnt(c_rnd),
    .end_of_game(c_eog), .winner(c_win), .bad_roll(c_bad));

  typedef struct {
    integer st, iv1, id1, iv2, id2;
    integer s1, s2, trn, rnd, eog, win, bad, r1, r2;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm, input integer act, input integer exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // drive one cycle of inputs at negedge, return 1 time unit after the rising edge
  task automatic step(input logic s, input logic iv1, input logic [2:0] id1,
                      input logic iv2, input logic [2:0] id2);
    @(negedge clk);
    start = s; v1 = iv1; d1 = id1; v2 = iv2; d2 = id2;
    @(posedge clk);
    #1;
    start = 1'b0; v1 = 1'b0; d1 = 3'd0; v2 = 1'b0; d2 = 3'd0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " s1"},  integer'(a_s1),  0);
    chk({tag, " s2"},  integer'(a_s2),  0);
    chk({tag, " rnd"}, integer'(a_rnd), 0);
    chk({tag, " trn"}, integer'(a_trn), 0);
    chk({tag, " eog"}, integer'(a_eog), 0);
    chk({tag, " win"}, integer'(a_win), 0);
    chk({tag, " bad"}, integer'(a_bad), 0);
    chk({tag, " r1"},  integer'(a_r1),  0);
    chk({tag, " r2"},  integer'(a_r2),  0);
  endtask

  initial begin
    //          st iv1 d1 iv2 d2   s1 s2 trn rnd eog win bad r1 r2
    vt[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};  // idle
    vt[1]  = '{0, 1, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};  // roll in idle ignored
    vt[2]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0};  // start
    vt[3]  = '{0, 0, 0, 1, 5,   0, 0, 0, 0, 0, 0, 0, 1, 0};  // P2 out of turn
    vt[4]  = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1, 0};  // face 0
    vt[5]  = '{0, 1, 7, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1, 0};  // face 7
    vt[6]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0};  // pulse ends
    vt[7]  = '{0, 1, 6, 0, 0,   6, 0, 1, 0, 0, 0, 0, 0, 1};
    vt[8]  = '{0, 1, 5, 0, 0,   6, 0, 1, 0, 0, 0, 0, 0, 1};  // P1 out of turn
    vt[9]  = '{0, 0, 0, 1, 4,   6, 4, 0, 1, 0, 0, 0, 1, 0};
    vt[10] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0};  // restart
    vt[11] = '{0, 1, 3, 0, 0,   3, 0, 1, 0, 0, 0, 0, 0, 1};
    vt[12] = '{0, 0, 0, 1, 3,   3, 3, 0, 1, 0, 0, 0, 1, 0};
    vt[13] = '{0, 1, 3, 0, 0,   6, 3, 1, 1, 0, 0, 0, 0, 1};
    vt[14] = '{0, 0, 0, 1, 7,   6, 3, 1, 1, 0, 0, 1, 0, 1};  // P2 bad face
    vt[15] = '{0, 0, 0, 1, 3,   6, 6, 0, 2, 0, 0, 0, 1, 0};
    vt[16] = '{0, 1, 3, 0, 0,   9, 6, 1, 2, 0, 0, 0, 0, 1};
    vt[17] = '{0, 0, 0, 1, 3,   9, 9, 0, 3, 1, 3, 0, 0, 0};  // round limit, tie
    vt[18] = '{0, 1, 4, 1, 4,   9, 9, 0, 3, 1, 3, 0, 0, 0};  // ignored in DONE
    vt[19] = '{0, 0, 0, 1, 0,   9, 9, 0, 3, 1, 3, 0, 0, 0};  // no bad_roll in DONE

    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("por");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(vt[i].st[0], vt[i].iv1[0], vt[i].id1[2:0], vt[i].iv2[0], vt[i].id2[2:0]);
      chk($sformatf("row%0d s1", i),  integer'(a_s1),  vt[i].s1);
      chk($sformatf("row%0d s2", i),  integer'(a_s2),  vt[i].s2);
      chk($sformatf("row%0d trn", i), integer'(a_trn), vt[i].trn);
      chk($sformatf("row%0d rnd", i), integer'(a_rnd), vt[i].rnd);
      chk($sformatf("row%0d eog", i), integer'(a_eog), vt[i].eog);
      chk($sformatf("row%0d win", i), integer'(a_win), vt[i].win);
      chk($sformatf("row%0d bad", i), integer'(a_bad), vt[i].bad);
      chk($sformatf("row%0d r1", i),  integer'(a_r1),  vt[i].r1);
      chk($sformatf("row%0d r2", i),  integer'(a_r2),  vt[i].r2);
    end

    // P1 reaches the target on its fourth roll
    step(1, 0, 0, 0, 0);
    step(0, 1, 6, 0, 0);
    chk("win s1 first", integer'(b_s1), 6);
    step(0, 0, 0, 1, 1);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("win s1 18", integer'(b_s1), 18);
    chk("win rnd 3", integer'(b_rnd), 3);
    chk("win eog pre", integer'(b_eog), 0);
    step(0, 1, 2, 0, 0);
    chk("win s1 20", integer'(b_s1), 20);
    chk("win eog", integer'(b_eog), 1);
    chk("win winner", integer'(b_win), 1);
    chk("win r1", integer'(b_r1), 0);
    chk("win trn", integer'(b_trn), 0);
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 3);
    chk("win frozen s1", integer'(b_s1), 20);
    chk("win frozen s2", integer'(b_s2), 3);
    chk("win frozen winner", integer'(b_win), 1);

    // start beats a same-cycle P1 handshake mid-game
    step(1, 0, 0, 0, 0);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("mid s1 12", integer'(a_s1), 12);
    chk("mid trn", integer'(a_trn), 0);
    step(1, 1, 5, 0, 0);
    chk("restart s1", integer'(a_s1), 0);
    chk("restart s2", integer'(a_s2), 0);
    chk("restart rnd", integer'(a_rnd), 0);
    chk("restart trn", integer'(a_trn), 0);
    chk("restart r1", integer'(a_r1), 1);
    step(0, 1, 6, 0, 0);
    chk("restart roll s1", integer'(a_s1), 6);
    chk("restart roll trn", integer'(a_trn), 1);

    // asynchronous reset mid-cycle, then release
    reset = 1'b0;
    #2;
    chk_reset_a("async");
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, 6, 0, 0);
    chk("post-rst idle s1", integer'(a_s1), 0);
    chk("post-rst idle r1", integer'(a_r1), 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0);
    chk("post-rst s1", integer'(a_s1), 4);

    // saturation at 255
    step(1, 0, 0, 0, 0);
    for (int r = 0; r < 42; r++) begin
      step(0, 1, 6, 0, 0);
      step(0, 0, 0, 1, 6);
    end
    chk("sat s1 252", integer'(c_s1), 252);
    step(0, 1, 6, 0, 0);
    chk("sat s1", integer'(c_s1), 255);
    step(0, 0, 0, 1, 6);
    chk("sat s2", integer'(c_s2), 255);
    chk("sat rnd", integer'(c_rnd), 43);
    step(0, 1, 6, 0, 0);
    chk("sat s1 hold", integer'(c_s1), 255);
    chk("sat eog", integer'(c_eog), 0);
    chk("sat trn", integer'(c_trn), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
